// File: rtl/vga_rtc_refresh_ctrl_pkg.sv
// Shared definitions for the RTC-to-overlay refresh sequencer and the VGA renderer.
package vga_rtc_refresh_ctrl_pkg;

  localparam int unsigned NUM_FIELDS = 9;

  // Field indices, also used by the renderer for its bit-slice selection
  localparam logic [3:0] F_DIA   = 4'd0;
  localparam logic [3:0] F_MES   = 4'd1;
  localparam logic [3:0] F_ANIO  = 4'd2;
  localparam logic [3:0] F_HORA  = 4'd3;
  localparam logic [3:0] F_MIN   = 4'd4;
  localparam logic [3:0] F_SEG   = 4'd5;
  localparam logic [3:0] F_HORAT = 4'd6;
  localparam logic [3:0] F_MINT  = 4'd7;
  localparam logic [3:0] F_SEGT  = 4'd8;

  typedef enum logic [1:0] {IDLE, REQ, WAIT, COMMIT} state_t;

  function automatic logic bcd_bad(input logic [7:0] v);
    return (v[7:4] > 4'd9) || (v[3:0] > 4'd9);
  endfunction

endpackage

// File: rtl/vga_rtc_refresh_ctrl_if.sv
// Request/acknowledge read bus between the refresh sequencer and the RTC controller.
interface vga_rtc_refresh_ctrl_if;
  logic       rtc_req;
  logic [3:0] rtc_addr;
  logic       rtc_ack;
  logic [7:0] rtc_data;

  modport master (output rtc_req, rtc_addr, input rtc_ack, rtc_data);
  modport slave  (input rtc_req, rtc_addr, output rtc_ack, rtc_data);
endinterface

// File: rtl/vga_rtc_refresh_ctrl_rtc_ack_timer.sv
// Loadable down-counter; expired is high while the count sits at zero.
module rtc_ack_timer #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             en,
  input  logic [WIDTH-1:0] load_val,
  output logic             expired
);
  logic [WIDTH-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst)                   cnt <= '0;
    else if (load)             cnt <= load_val;
    else if (en && cnt != '0)  cnt <= cnt - WIDTH'(1);
  end

  assign expired = (cnt == '0);
endmodule

// File: rtl/vga_rtc_refresh_ctrl.sv
// Per-frame RTC field fetch with atomic commit to the overlay and alarm blink phase.
// Optional macro ALARM_BLINK_EN: frame-counted blink; otherwise blink_on = registered alarma.
module vga_rtc_refresh_ctrl
  import vga_rtc_refresh_ctrl_pkg::*;
#(
  parameter int unsigned ACK_TIMEOUT = 255
`ifdef ALARM_BLINK_EN
  , parameter int unsigned BLINK_FRAMES = 30
`endif
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          frame_tick,
  vga_rtc_refresh_ctrl_if.master        rtc,
  input  logic                          alarma,
  output logic [8*NUM_FIELDS-1:0]       fields_out,
  output logic                          fields_valid,
  output logic                          commit_pulse,
  output logic                          timeout_err,
  output logic                          bcd_err,
  output logic                          blink_on
);
  localparam int unsigned TW = $clog2(ACK_TIMEOUT + 1);

  state_t                       state, state_d;
  logic [3:0]                   idx, idx_d;
  logic                         req_q, req_d;
  logic [NUM_FIELDS-1:0][7:0]   shadow, shadow_d, fields_q, fields_d;
  logic                         valid_d, commit_d, tmo_d, bcd_d;
  logic                         tmr_load, tmr_expired;

  rtc_ack_timer #(.WIDTH(TW)) u_ack_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (tmr_load),
    .en       (state == WAIT),
    .load_val (TW'(ACK_TIMEOUT)),
    .expired  (tmr_expired)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      idx          <= F_DIA;
      req_q        <= 1'b0;
      shadow       <= '0;
      fields_q     <= '0;
      fields_valid <= 1'b0;
      commit_pulse <= 1'b0;
      timeout_err  <= 1'b0;
      bcd_err      <= 1'b0;
    end else begin
      state        <= state_d;
      idx          <= idx_d;
      req_q        <= req_d;
      shadow       <= shadow_d;
      fields_q     <= fields_d;
      fields_valid <= valid_d;
      commit_pulse <= commit_d;
      timeout_err  <= tmo_d;
      bcd_err      <= bcd_d;
    end
  end

  // The first request is issued straight from IDLE so rtc_req rises the cycle after
  // frame_tick; REQ is the one-cycle gap with rtc_req low between later fields.
  always_comb begin
    state_d  = state;
    idx_d    = idx;
    req_d    = req_q;
    shadow_d = shadow;
    fields_d = fields_q;
    valid_d  = fields_valid;
    commit_d = 1'b0;
    tmo_d    = 1'b0;
    bcd_d    = bcd_err;
    tmr_load = 1'b0;
    case (state)
      IDLE: if (frame_tick) begin
        idx_d    = F_DIA;
        req_d    = 1'b1;
        tmr_load = 1'b1;
        state_d  = WAIT;
      end
      REQ: begin
        req_d    = 1'b1;
        tmr_load = 1'b1;
        state_d  = WAIT;
      end
      WAIT: begin
        if (rtc.rtc_ack) begin
          shadow_d[idx] = rtc.rtc_data;
          if (bcd_bad(rtc.rtc_data)) bcd_d = 1'b1;
          req_d = 1'b0;
          if (idx == F_SEGT) begin
            state_d = COMMIT;
          end else begin
            idx_d   = idx + 4'd1;
            state_d = REQ;
          end
        end else if (tmr_expired) begin
          req_d    = 1'b0;
          tmo_d    = 1'b1;
          shadow_d = '0;
          idx_d    = F_DIA;
          state_d  = IDLE;
        end
      end
      COMMIT: begin
        fields_d = shadow;
        commit_d = 1'b1;
        valid_d  = 1'b1;
        idx_d    = F_DIA;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign rtc.rtc_req  = req_q;
  assign rtc.rtc_addr = idx;
  assign fields_out   = fields_q;

`ifdef ALARM_BLINK_EN
  localparam int unsigned BW = $clog2(BLINK_FRAMES + 1);
  logic [BW-1:0] blink_cnt;

  always_ff @(posedge clk) begin
    if (rst || !alarma) begin
      blink_cnt <= '0;
      blink_on  <= 1'b0;
    end else if (frame_tick) begin
      if (blink_cnt == BW'(BLINK_FRAMES - 1)) begin
        blink_cnt <= '0;
        blink_on  <= ~blink_on;
      end else begin
        blink_cnt <= blink_cnt + BW'(1);
      end
    end
  end
`else
  always_ff @(posedge clk) begin
    if (rst) blink_on <= 1'b0;
    else     blink_on <= alarma;
  end
`endif

endmodule

// File: tb/tb_vga_rtc_refresh_ctrl.sv
// Scoreboard bench for vga_rtc_refresh_ctrl with a delay-configurable RTC responder.
module tb_vga_rtc_refresh_ctrl;
  localparam int unsigned BLINK_FRAMES = 30;

  typedef struct {
    logic        tmo;
    logic [71:0] fields;
    int          tick;
    int          lat;
  } sb_t;

  logic        clk = 1'b0;
  logic        rst, frame_tick, alarma;
  logic [71:0] fields_out;
  logic        fields_valid, commit_pulse, timeout_err, bcd_err, blink_on;

  vga_rtc_refresh_ctrl_if bus();

  vga_rtc_refresh_ctrl #(
    .ACK_TIMEOUT  (255)
`ifdef ALARM_BLINK_EN
    , .BLINK_FRAMES (BLINK_FRAMES)
`endif
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .frame_tick   (frame_tick),
    .rtc          (bus.master),
    .alarma       (alarma),
    .fields_out   (fields_out),
    .fields_valid (fields_valid),
    .commit_pulse (commit_pulse),
    .timeout_err  (timeout_err),
    .bcd_err      (bcd_err),
    .blink_on     (blink_on)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int n_commit = 0;
  sb_t sb_q[$];
  sb_t mon_e;

  logic [7:0] resp_data [9];
  int         resp_delay;
  int         stall_field;
  int         w;
  logic [3:0] rise_addr;

  task automatic check(input string tag, input logic [71:0] got, input logic [71:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // RTC responder: acks resp_delay cycles after it first sees rtc_req high
  initial begin
    bus.rtc_ack  = 1'b0;
    bus.rtc_data = '0;
    w = 0;
    forever begin
      @(negedge clk);
      bus.rtc_ack = 1'b0;
      if (rst || !bus.rtc_req) begin
        w = 0;
      end else begin
        if (w == 0) rise_addr = bus.rtc_addr;
        w++;
        if (w == resp_delay + 1 && int'(bus.rtc_addr) != stall_field) begin
          check("addr_stable", 72'(bus.rtc_addr), 72'(rise_addr));
          bus.rtc_ack  = 1'b1;
          bus.rtc_data = resp_data[bus.rtc_addr];
        end
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && (commit_pulse || timeout_err)) begin
      if (sb_q.size() == 0) begin
        check("unexpected_event", 72'(sb_q.size()), 72'd1);
      end else begin
        mon_e = sb_q.pop_front();
        check("event_kind", 72'(timeout_err), 72'(mon_e.tmo));
        check("fields_out", fields_out, mon_e.fields);
        if (!mon_e.tmo) check("latency", 72'(cyc - mon_e.tick), 72'(mon_e.lat));
        if (commit_pulse) n_commit++;
      end
    end
  end

  function automatic logic [71:0] pack_data();
    logic [71:0] r;
    for (int i = 0; i < 9; i++) r[i*8 +: 8] = resp_data[i];
    return r;
  endfunction

  task automatic pulse_tick();
    frame_tick = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0;
  endtask

  task automatic start_frame(input logic tmo, input logic [71:0] f, input int lat);
    sb_q.push_back('{tmo, f, cyc + 1, lat});
    pulse_tick();
  endtask

  task automatic drain(input int bound);
    for (int i = 0; i < bound && sb_q.size() != 0; i++) @(negedge clk);
    @(negedge clk);
    check("drain", 72'(sb_q.size()), 72'd0);
  endtask

  logic [71:0] slow_fields;
  int c0;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; frame_tick = 1'b0; alarma = 1'b0;
    resp_delay = 1; stall_field = -1;
    resp_data = '{8'h10, 8'h04, 8'h00, 8'h50, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    repeat (3) @(negedge clk);
    check("rst_req", 72'(bus.rtc_req), 72'd0);
    check("rst_addr", 72'(bus.rtc_addr), 72'd0);
    check("rst_fields", fields_out, 72'd0);
    check("rst_valid", 72'(fields_valid), 72'd0);
    check("rst_errs", 72'({commit_pulse, timeout_err, bcd_err, blink_on}), 72'd0);
    rst = 1'b0;
    @(negedge clk);

    // Basic refresh, ack one cycle after each request
    start_frame(1'b0, pack_data(), 27);
    drain(100);
    check("basic_value", fields_out, 72'h00_00_00_00_00_50_00_04_10);
    check("basic_valid", 72'(fields_valid), 72'd1);

    // Slow responder
    resp_delay = 10;
    resp_data = '{8'h23, 8'h12, 8'h99, 8'h07, 8'h45, 8'h31, 8'h01, 8'h02, 8'h03};
    slow_fields = pack_data();
    start_frame(1'b0, slow_fields, 108);
    drain(200);

    // Hour field never acked: abort, previous frame kept, next frame normal
    resp_delay = 1; stall_field = 3;
    resp_data = '{8'h10, 8'h04, 8'h00, 8'h50, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    start_frame(1'b1, slow_fields, 0);
    drain(400);
    check("tmo_kept", fields_out, slow_fields);
    check("tmo_req_low", 72'(bus.rtc_req), 72'd0);
    stall_field = -1;
    start_frame(1'b0, pack_data(), 27);
    drain(100);

    // Overlapping ticks every 5 cycles: a single refresh
    c0 = n_commit;
    resp_data = '{8'h01, 8'h02, 8'h24, 8'h11, 8'h22, 8'h33, 8'h00, 8'h15, 8'h59};
    start_frame(1'b0, pack_data(), 27);
    for (int k = 0; k < 5; k++) begin
      repeat (4) @(negedge clk);
      pulse_tick();
    end
    drain(100);
    repeat (20) @(negedge clk);
    check("one_commit", 72'(n_commit - c0), 72'd1);

    // Reset during field 4
    sb_q.push_back('{1'b0, pack_data(), cyc + 1, 27});
    pulse_tick();
    for (int i = 0; i < 100 && !(bus.rtc_req && bus.rtc_addr == 4'd4); i++) @(negedge clk);
    check("reach_f4", 72'(bus.rtc_addr), 72'd4);
    rst = 1'b1;
    sb_q.delete();
    @(negedge clk);
    check("midrst_req", 72'(bus.rtc_req), 72'd0);
    check("midrst_fields", fields_out, 72'd0);
    check("midrst_valid", 72'(fields_valid), 72'd0);
    rst = 1'b0;
    @(negedge clk);

    // Bad BCD hour: sticky until reset
    resp_data = '{8'h10, 8'h04, 8'h00, 8'h5A, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    start_frame(1'b0, pack_data(), 27);
    drain(100);
    check("bcd_set", 72'(bcd_err), 72'd1);
    resp_data[3] = 8'h12;
    start_frame(1'b0, pack_data(), 27);
    drain(100);
    check("bcd_sticky", 72'(bcd_err), 72'd1);
    rst = 1'b1;
    @(negedge clk);
    check("bcd_cleared", 72'(bcd_err), 72'd0);
    rst = 1'b0;
    @(negedge clk);

`ifdef ALARM_BLINK_EN
    alarma = 1'b1;
    @(negedge clk);
    for (int k = 1; k <= 90; k++) begin
      start_frame(1'b0, pack_data(), 27);
      check($sformatf("blink_tick%0d", k), 72'(blink_on), 72'(((k / BLINK_FRAMES) % 2) == 1));
      repeat (30) @(negedge clk);
    end
    alarma = 1'b0;
    @(negedge clk);
    check("blink_drop", 72'(blink_on), 72'd0);
`else
    alarma = 1'b1;
    @(negedge clk);
    check("solid_on", 72'(blink_on), 72'd1);
    alarma = 1'b0;
    @(negedge clk);
    check("solid_off", 72'(blink_on), 72'd0);
`endif
    drain(100);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
